// File: rtl/dmx512_tx_param.sv
// DMX512-A transmitter: mark-before-break, BREAK, MAB, start code and up to NUM_SLOTS slots, looping while tx_en.
// Latency: BREAK begins once the mark timer expires with tx_en high; all outputs registered. No backpressure.
// Define DMX_DBUF_EN for a double-buffered universe (writes to back bank, commit swaps at next BREAK).
module dmx512_tx_param #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BAUD      = 250_000,
    parameter int NUM_SLOTS = 512,
    parameter int IDLE_US   = 50,
    parameter int BREAK_US  = 100,
    parameter int MAB_US    = 12,
    localparam int ADDR_W   = $clog2(NUM_SLOTS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_en,
    input  logic [7:0]        start_code,
    input  logic [ADDR_W-1:0] slot_count,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              commit,
    output logic              busy,
    output logic              pkt_start,
    output logic              pkt_done,
    output logic              dmx_out
);
    localparam int BIT_CYC    = CLK_HZ / BAUD;
    localparam int CYC_PER_US = CLK_HZ / 1_000_000;
    localparam int IDLE_CYC   = CYC_PER_US * IDLE_US;
    localparam int BREAK_CYC  = CYC_PER_US * BREAK_US;
    localparam int MAB_CYC    = CYC_PER_US * MAB_US;
    localparam int MAX_A      = (IDLE_CYC > BREAK_CYC) ? IDLE_CYC : BREAK_CYC;
    localparam int MAX_B      = (MAB_CYC > BIT_CYC) ? MAB_CYC : BIT_CYC;
    localparam int MAX_CYC    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TW         = $clog2(MAX_CYC + 1);
    localparam int MW         = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BREAK, S_MAB, S_FRAME} state_t;

    state_t            state;
    logic [TW-1:0]     timer;
    logic [3:0]        bit_idx;
    logic [ADDR_W-1:0] slot_idx;
    logic [ADDR_W-1:0] cnt_lat;
    logic [7:0]        sc_lat;
    logic [7:0]        rd_data;

    logic [ADDR_W-1:0] cnt_eff;
    logic              bit_end;
    logic [7:0]        cur_byte;
    logic              next_bit;
    logic              rd_en;
    logic              wr_ok;
    logic [MW-1:0]     wr_idx;
    logic [MW-1:0]     rd_idx;

    assign cnt_eff  = (slot_count == '0 || slot_count > ADDR_W'(NUM_SLOTS)) ? ADDR_W'(NUM_SLOTS) : slot_count;
    assign bit_end  = (timer == TW'(BIT_CYC - 1));
    assign cur_byte = (slot_idx == '0) ? sc_lat : rd_data;
    assign next_bit = (bit_idx < 4'd8) ? cur_byte[bit_idx[2:0]] : 1'b1;
    // Next slot is fetched at the first stop bit, so writes during the current frame cannot tear it.
    assign rd_en    = (state == S_FRAME) && (bit_idx == 4'd9) && (timer == '0) && (slot_idx < cnt_lat);
    assign rd_idx   = MW'(slot_idx);
    assign wr_ok    = wr_en && (wr_addr != '0) && (wr_addr <= ADDR_W'(NUM_SLOTS));
    assign wr_idx   = MW'(wr_addr - ADDR_W'(1));

`ifdef DMX_DBUF_EN
    logic       front;
    logic       commit_pend;
    logic [7:0] mem [2][NUM_SLOTS];

    always_ff @(posedge clk) begin
        if (wr_ok) mem[~front][wr_idx] <= wr_data;
        if (rd_en) rd_data <= mem[front][rd_idx];
    end
`else
    logic       unused_commit;
    logic [7:0] mem [NUM_SLOTS];

    assign unused_commit = commit;

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_idx] <= wr_data;
        if (rd_en) rd_data <= mem[rd_idx];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            timer     <= '0;
            bit_idx   <= '0;
            slot_idx  <= '0;
            cnt_lat   <= '0;
            sc_lat    <= '0;
            dmx_out   <= 1'b1;
            busy      <= 1'b0;
            pkt_start <= 1'b0;
            pkt_done  <= 1'b0;
`ifdef DMX_DBUF_EN
            front       <= 1'b0;
            commit_pend <= 1'b0;
`endif
        end else begin
            pkt_start <= 1'b0;
            pkt_done  <= 1'b0;
`ifdef DMX_DBUF_EN
            if (commit) commit_pend <= 1'b1;
`endif
            case (state)
                S_IDLE: begin
                    if (timer >= TW'(IDLE_CYC - 1) && tx_en) begin
                        state     <= S_BREAK;
                        timer     <= '0;
                        dmx_out   <= 1'b0;
                        busy      <= 1'b1;
                        pkt_start <= 1'b1;
                        sc_lat    <= start_code;
                        cnt_lat   <= cnt_eff;
`ifdef DMX_DBUF_EN
                        if (commit || commit_pend) begin
                            front       <= ~front;
                            commit_pend <= 1'b0;
                        end
`endif
                    end else if (timer < TW'(IDLE_CYC - 1)) begin
                        timer <= timer + TW'(1);
                    end
                end
                S_BREAK: begin
                    if (timer == TW'(BREAK_CYC - 1)) begin
                        state   <= S_MAB;
                        timer   <= '0;
                        dmx_out <= 1'b1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_MAB: begin
                    if (timer == TW'(MAB_CYC - 1)) begin
                        state    <= S_FRAME;
                        timer    <= '0;
                        bit_idx  <= '0;
                        slot_idx <= '0;
                        dmx_out  <= 1'b0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_FRAME: begin
                    if (!bit_end) begin
                        timer <= timer + TW'(1);
                    end else begin
                        timer <= '0;
                        if (bit_idx != 4'd10) begin
                            bit_idx <= bit_idx + 4'd1;
                            dmx_out <= next_bit;
                        end else if (slot_idx < cnt_lat) begin
                            slot_idx <= slot_idx + ADDR_W'(1);
                            bit_idx  <= '0;
                            dmx_out  <= 1'b0;
                        end else begin
                            state    <= S_IDLE;
                            dmx_out  <= 1'b1;
                            busy     <= 1'b0;
                            pkt_done <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmx512_tx_param.sv
// Bench for dmx512_tx_param: random universes checked against a waveform model built from the DMX packet rules.
module tb_dmx512_tx_param;
    localparam int NS        = 8;
    localparam int AW        = $clog2(NS + 1);
    localparam int BIT_CYC   = 4;
    localparam int IDLE_CYC  = 50;
    localparam int BREAK_CYC = 100;
    localparam int MAB_CYC   = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tx_en = 1'b0;
    logic [7:0]    start_code = '0;
    logic [AW-1:0] slot_count = '0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [7:0]    wr_data = '0;
    logic          commit = 1'b0;
    logic          busy, pkt_start, pkt_done, dmx_out;

    int checks = 0;
    int failures = 0;

    // Reference state: two banks of slot bytes (only bank 0 used in single-bank builds).
    logic [7:0]    mbank [0:1][0:NS];
    int            mfront = 0;
    bit            mpend = 1'b0;
    int            wq_a[$];
    logic [7:0]    wq_d[$];
    bit            want_commit = 1'b0;
    logic [7:0]    cur_sc, next_sc;
    logic [AW-1:0] cur_cnt, next_cnt;
    logic [7:0]    dec[$];

    dmx512_tx_param #(
        .CLK_HZ(1_000_000), .BAUD(250_000), .NUM_SLOTS(NS),
        .IDLE_US(50), .BREAK_US(100), .MAB_US(12)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .start_code(start_code),
        .slot_count(slot_count), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .commit(commit), .busy(busy), .pkt_start(pkt_start), .pkt_done(pkt_done),
        .dmx_out(dmx_out)
    );

    always #5 clk = ~clk;

    function automatic void model_write(input int a, input logic [7:0] d);
        if (a >= 1 && a <= NS) begin
`ifdef DMX_DBUF_EN
            mbank[1 - mfront][a] = d;
`else
            mbank[0][a] = d;
`endif
        end
    endfunction

    function automatic void model_commit();
`ifdef DMX_DBUF_EN
        mpend = 1'b1;
`endif
    endfunction

    function automatic void model_pkt_start();
        if (mpend) begin
            mfront = 1 - mfront;
            mpend = 1'b0;
        end
    endfunction

    task automatic queue_write(input int a, input logic [7:0] d);
        wq_a.push_back(a);
        wq_d.push_back(d);
    endtask

    task automatic queue_universe();
        for (int s = 1; s <= NS; s++) queue_write(s, 8'($urandom));
        want_commit = 1'b1;
    endtask

    task automatic drive_bus();
        int a;
        logic [7:0] d;
        wr_en = 1'b0;
        commit = 1'b0;
        if (wq_a.size() > 0) begin
            a = wq_a.pop_front();
            d = wq_d.pop_front();
            wr_en = 1'b1;
            wr_addr = AW'(a);
            wr_data = d;
            model_write(a, d);
        end else if (want_commit) begin
            commit = 1'b1;
            want_commit = 1'b0;
            model_commit();
        end
    endtask

    task automatic roll_next(input int cnt);
        cur_sc = next_sc;
        cur_cnt = next_cnt;
        next_sc = 8'($urandom);
        next_cnt = AW'(cnt);
    endtask

    task automatic wait_start(input int exp_gap);
        int n;
        int bad;
        n = 0;
        bad = 0;
        drive_bus();
        do begin
            @(negedge clk);
            n++;
            if (pkt_start !== 1'b1) begin
                if (dmx_out !== 1'b1 || busy !== 1'b0) bad++;
                drive_bus();
            end
        end while (pkt_start !== 1'b1 && n < exp_gap + 300);
        model_pkt_start();
        checks++;
        assert (n === exp_gap) else begin
            failures++;
            $error("FAIL idle_gap got=%0d want=%0d", n, exp_gap);
        end
        checks++;
        assert (bad === 0) else begin
            failures++;
            $error("FAIL idle_line bad_cycles=%0d want=0", bad);
        end
    endtask

    task automatic check_packet(input int txoff_at, input int commit_at);
        logic       exp_q[$];
        logic       obs_q[$];
        logic [7:0] frames[$];
        logic [10:0] w;
        logic [7:0] d;
        int eff, bad, first, base;
        bad = 0;
        first = -1;
        eff = (cur_cnt == 0 || cur_cnt > NS) ? NS : int'(cur_cnt);
        frames.push_back(cur_sc);
        for (int k = 1; k <= eff; k++) frames.push_back(mbank[mfront][k]);
        repeat (BREAK_CYC) exp_q.push_back(1'b0);
        repeat (MAB_CYC) exp_q.push_back(1'b1);
        foreach (frames[f]) begin
            w = {2'b11, frames[f], 1'b0};
            for (int b = 0; b < 11; b++) repeat (BIT_CYC) exp_q.push_back(w[b]);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) @(negedge clk);
            obs_q.push_back(dmx_out);
            if (dmx_out !== exp_q[i] || busy !== 1'b1 || pkt_done !== 1'b0 || pkt_start !== (i == 0)) begin
                bad++;
                if (first < 0) first = i;
            end
            wr_en = 1'b0;
            commit = 1'b0;
            if (i == 4) begin
                start_code = next_sc;
                slot_count = next_cnt;
            end
            if (i == txoff_at) tx_en = 1'b0;
            if (commit_at >= 0 && (i == commit_at || i == commit_at + 20)) begin
                commit = 1'b1;
                model_commit();
            end
        end
        checks++;
        assert (bad === 0) else begin
            failures++;
            $error("FAIL packet_wave bad_cycles=%0d first_bad=%0d want_len=%0d", bad, first, exp_q.size());
        end
        dec.delete();
        foreach (frames[f]) begin
            base = BREAK_CYC + MAB_CYC + f * 11 * BIT_CYC;
            for (int k = 0; k < 8; k++) d[k] = obs_q[base + (k + 1) * BIT_CYC + BIT_CYC / 2];
            dec.push_back(d);
        end
        @(negedge clk);
        checks++;
        assert ({pkt_done, busy, dmx_out} === 3'b101) else begin
            failures++;
            $error("FAIL pkt_done_end got done/busy/line=%b%b%b want=101", pkt_done, busy, dmx_out);
        end
    endtask

    task automatic check_slot1(input string tag, input logic [7:0] want);
        logic [7:0] got;
        got = (dec.size() > 1) ? dec[1] : 8'hxx;
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s slot1 got=%h want=%h", tag, got, want);
        end
    endtask

    initial begin
        int bad;
        logic [7:0] old1;
        logic [7:0] got_sc;

        // Packet with a single 0xA5 slot after reset
        tx_en = 1'b1;
        start_code = 8'h00;
        slot_count = AW'(1);
        next_sc = 8'h00;
        next_cnt = AW'(1);
        repeat (3) @(negedge clk);
        checks++;
        assert ({dmx_out, busy, pkt_start, pkt_done} === 4'b1000) else begin
            failures++;
            $error("FAIL reset_outputs got=%b want=1000", {dmx_out, busy, pkt_start, pkt_done});
        end
        queue_write(1, 8'hA5);
        want_commit = 1'b1;
        roll_next(0);
        rst_n = 1'b1;
        wait_start(IDLE_CYC);
        check_packet(-1, -1);
        check_slot1("first_packet", 8'hA5);
        got_sc = (dec.size() > 0) ? dec[0] : 8'hxx;
        checks++;
        assert (dec.size() === 2 && got_sc === 8'h00) else begin
            failures++;
            $error("FAIL first_packet frames=%0d sc=%h want frames=2 sc=00", dec.size(), got_sc);
        end

        // Random universes, clamped counts, ignored out-of-range writes
        for (int p = 0; p < 5; p++) begin
            roll_next((p == 0) ? 12 : (p == 1) ? 8 : (p == 4) ? 5 : $urandom_range(1, NS));
            queue_universe();
            if (p == 2) begin
                queue_write(0, 8'h55);
                queue_write(9, 8'h66);
            end
            wait_start(IDLE_CYC);
            check_packet(-1, -1);
            checks++;
            assert (dec.size() === ((cur_cnt == 0 || cur_cnt > NS) ? NS + 1 : int'(cur_cnt) + 1)) else begin
                failures++;
                $error("FAIL slot_count frames=%0d cnt_in=%0d", dec.size(), cur_cnt);
            end
        end

        // tx_en dropped during slot 3: packet completes, line holds mark
        roll_next($urandom_range(1, NS));
        queue_universe();
        wait_start(IDLE_CYC);
        check_packet(BREAK_CYC + MAB_CYC + 3 * 11 * BIT_CYC + 6, -1);
        bad = 0;
        queue_universe();
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (pkt_start !== 1'b0 || pkt_done !== 1'b0 || busy !== 1'b0 || dmx_out !== 1'b1) bad++;
            drive_bus();
        end
        checks++;
        assert (bad === 0) else begin
            failures++;
            $error("FAIL txen_hold bad_cycles=%0d want=0", bad);
        end
        tx_en = 1'b1;
        roll_next($urandom_range(1, NS));
        wait_start(1);
        check_packet(-1, -1);

`ifdef DMX_DBUF_EN
        // Back-bank write is invisible until commit; two commits give one swap
        roll_next($urandom_range(1, NS));
        old1 = mbank[mfront][1];
        queue_write(1, 8'h11);
        wait_start(IDLE_CYC);
        check_packet(-1, -1);
        check_slot1("dbuf_nocommit", old1);
        roll_next($urandom_range(1, NS));
        want_commit = 1'b1;
        wait_start(IDLE_CYC);
        check_packet(-1, 150);
        check_slot1("dbuf_commit", 8'h11);
        roll_next($urandom_range(1, NS));
        wait_start(IDLE_CYC);
        check_packet(-1, -1);
        check_slot1("dbuf_double_commit", old1);
`else
        old1 = 8'($urandom);
        roll_next($urandom_range(1, NS));
        queue_write(1, old1);
        want_commit = 1'b0;
        wait_start(IDLE_CYC);
        check_packet(-1, -1);
        check_slot1("single_bank_write", old1);
`endif

        // Reset in the middle of BREAK
        roll_next($urandom_range(1, NS));
        wait_start(IDLE_CYC);
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        assert ({dmx_out, busy} === 2'b10) else begin
            failures++;
            $error("FAIL reset_midbreak got line/busy=%b%b want=10", dmx_out, busy);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_start(IDLE_CYC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
